// File: rtl/instr_sequencer.sv
// Program sequencer for the 8-puzzle solver core: fetches op words from the
// instruction ROM, resolves JMP/JNZ locally and issues everything else to the datapath.
module instr_sequencer #(
    parameter int          PC_W      = 6,
    parameter int          OP_W      = 16,
    parameter int          START_PC  = 0,
    parameter logic [4:0]  OPC_JMP   = 5'd16,
    parameter logic [4:0]  OPC_JNZ   = 5'd17,
    parameter logic [4:0]  OPC_STORE = 5'd18
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [PC_W-1:0] pc,
    input  logic [OP_W-1:0] op,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [OP_W-1:0] issue_op,
    input  logic            done_valid,
    input  logic            done_flag,
    output logic            flag,
    output logic            busy,
    output logic            halted,
    output logic [15:0]     retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_WAIT   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [PC_W-1:0] START_PC_L = START_PC[PC_W-1:0];
    localparam logic [PC_W-1:0] PC_ONE     = {{(PC_W-1){1'b0}}, 1'b1};

    function automatic logic is_jump(input logic [4:0] opc);
        is_jump = (opc == OPC_JMP) || (opc == OPC_JNZ);
    endfunction

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [OP_W-1:0] ir_q, ir_d;
    logic            flag_q, flag_d;
    logic [15:0]     retired_q, retired_d;
    logic            issue_valid_q, issue_valid_d;
    logic            busy_q, busy_d;
    logic            halted_q, halted_d;

    logic [15:0]     retired_inc_s;
    logic [PC_W-1:0] pc_inc_s;
    logic [4:0]      ir_opc_s;

    assign retired_inc_s = (retired_q == 16'hFFFF) ? retired_q : (retired_q + 16'd1);
    assign pc_inc_s      = pc_q + PC_ONE;
    assign ir_opc_s      = ir_q[OP_W-1:OP_W-5];

    // Next-state and next-register computation for the sequencer FSM.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        flag_d        = flag_q;
        retired_d     = retired_q;
        issue_valid_d = issue_valid_q;
        case (state_q)
            S_IDLE: begin
                pc_d      = START_PC_L;
                flag_d    = 1'b0;
                retired_d = 16'd0;
                if (start) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                ir_d          = op;
                issue_valid_d = !is_jump(op[OP_W-1:OP_W-5]);
                state_d       = S_DECODE;
            end
            S_DECODE: begin
                if (ir_opc_s == OPC_JMP) begin
                    pc_d      = ir_q[PC_W-1:0];
                    retired_d = retired_inc_s;
                    state_d   = S_FETCH;
                end else if (ir_opc_s == OPC_JNZ) begin
                    pc_d      = flag_q ? ir_q[PC_W-1:0] : pc_inc_s;
                    retired_d = retired_inc_s;
                    state_d   = S_FETCH;
                end else if (issue_valid_q && issue_ready) begin
                    issue_valid_d = 1'b0;
                    state_d       = S_WAIT;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_WAIT: begin
                if (done_valid) begin
                    flag_d    = done_flag;
                    retired_d = retired_inc_s;
                    // STORE ends the search: park with pc still on the STORE.
                    if (ir_opc_s == OPC_STORE) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_inc_s;
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HALT: begin
                if (start) begin
                    pc_d      = START_PC_L;
                    flag_d    = 1'b0;
                    retired_d = 16'd0;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_HALT;
                end
            end
            default: begin
                state_d       = S_IDLE;
                issue_valid_d = 1'b0;
            end
        endcase
        busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_WAIT);
        halted_d = (state_d == S_HALT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= START_PC_L;
            ir_q          <= '0;
            flag_q        <= 1'b0;
            retired_q     <= 16'd0;
            issue_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            flag_q        <= flag_d;
            retired_q     <= retired_d;
            issue_valid_q <= issue_valid_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
        end
    end

    assign pc          = pc_q;
    assign issue_op    = ir_q;
    assign issue_valid = issue_valid_q;
    assign flag        = flag_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: behavioural ROM, hand-driven datapath,
// issue scoreboard checked by an independent monitor.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  pc;
    logic [15:0] op;
    logic        issue_valid;
    logic        issue_ready;
    logic [15:0] issue_op;
    logic        done_valid;
    logic        done_flag;
    logic        flag;
    logic        busy;
    logic        halted;
    logic [15:0] retired;

    logic [15:0] rom [64];
    logic [15:0] exp_q [$];
    int checks   = 0;
    int failures = 0;

    assign op = rom[pc];

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .op(op),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .done_valid(done_valid), .done_flag(done_flag), .flag(flag),
        .busy(busy), .halted(halted), .retired(retired)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted issue must match the next expected op word.
    always @(negedge clk) begin
        if (!rst && issue_valid && issue_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL issue_unexpected: got %h expected none", issue_op);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (issue_op !== e) begin
                    failures++;
                    $display("FAIL issue_op: got %h expected %h", issue_op, e);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
        rom[0]  = 16'h8005;  // JMP 5
        rom[5]  = 16'h9000;  // STORE
        rst = 1'b1; start = 1'b0; issue_ready = 1'b0; done_valid = 1'b0; done_flag = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_pc", {10'd0, pc}, 16'd0);
        chk("rst_valid", {15'd0, issue_valid}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_retired", retired, 16'd0);
        chk("rst_issue_op", issue_op, 16'd0);

        // JMP at pc 0
        start = 1'b1; step(); start = 1'b0;
        chk("jmp_fetch_pc", {10'd0, pc}, 16'd0);
        chk("jmp_busy", {15'd0, busy}, 16'd1);
        step();
        chk("jmp_decode_valid", {15'd0, issue_valid}, 16'd0);
        step();
        chk("jmp_target_pc", {10'd0, pc}, 16'd5);
        chk("jmp_retired", retired, 16'd1);
        chk("jmp_valid", {15'd0, issue_valid}, 16'd0);
        step();
        chk("store_valid", {15'd0, issue_valid}, 16'd1);
        exp_q.push_back(16'h9000);
        issue_ready = 1'b1; step(); issue_ready = 1'b0;
        done_valid = 1'b1; done_flag = 1'b0; step(); done_valid = 1'b0;
        chk("halt1_halted", {15'd0, halted}, 16'd1);
        chk("halt1_pc", {10'd0, pc}, 16'd5);
        chk("halt1_retired", retired, 16'd2);

        // Stalled non-jump at pc 0, then jumps and JNZ both ways, then STORE at 41
        rom[0]  = 16'h1234;  // opcode 2
        rom[1]  = 16'h8003;  // JMP 3
        rom[3]  = 16'h8809;  // JNZ 9
        rom[9]  = 16'h18AB;  // opcode 3
        rom[10] = 16'h8003;  // JMP 3
        rom[4]  = 16'h8029;  // JMP 41
        rom[41] = 16'h9055;  // STORE
        start = 1'b1; step(); start = 1'b0;
        chk("restart_pc", {10'd0, pc}, 16'd0);
        chk("restart_retired", retired, 16'd0);
        chk("restart_halted", {15'd0, halted}, 16'd0);
        step();
        exp_q.push_back(16'h1234);
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", {15'd0, issue_valid}, 16'd1);
            chk("stall_op", issue_op, 16'h1234);
            if (i == 3) issue_ready = 1'b1;
            step();
        end
        issue_ready = 1'b0;
        chk("wait_valid_low", {15'd0, issue_valid}, 16'd0);
        chk("wait_busy", {15'd0, busy}, 16'd1);
        step();
        chk("wait_pc_hold", {10'd0, pc}, 16'd0);
        done_valid = 1'b1; done_flag = 1'b1; step(); done_valid = 1'b0; done_flag = 1'b0;
        chk("done_flag", {15'd0, flag}, 16'd1);
        chk("done_pc", {10'd0, pc}, 16'd1);
        chk("done_retired", retired, 16'd1);
        step(); step();
        chk("jmp3_pc", {10'd0, pc}, 16'd3);
        step(); step();
        chk("jnz_taken_pc", {10'd0, pc}, 16'd9);
        chk("jnz_taken_flag", {15'd0, flag}, 16'd1);
        chk("jnz_taken_retired", retired, 16'd3);
        step();
        exp_q.push_back(16'h18AB);
        issue_ready = 1'b1; step(); issue_ready = 1'b0;
        done_valid = 1'b1; done_flag = 1'b0; step(); done_valid = 1'b0;
        chk("flag_clear", {15'd0, flag}, 16'd0);
        chk("pc_10", {10'd0, pc}, 16'd10);
        step(); step(); step(); step();
        chk("jnz_nt_pc", {10'd0, pc}, 16'd4);
        chk("jnz_nt_flag", {15'd0, flag}, 16'd0);
        chk("jnz_nt_retired", retired, 16'd6);
        step(); step();
        chk("jmp41_pc", {10'd0, pc}, 16'd41);
        step();
        exp_q.push_back(16'h9055);
        issue_ready = 1'b1; step(); issue_ready = 1'b0;
        done_valid = 1'b1; done_flag = 1'b1; step(); done_valid = 1'b0; done_flag = 1'b0;
        chk("halt2_halted", {15'd0, halted}, 16'd1);
        chk("halt2_busy", {15'd0, busy}, 16'd0);
        chk("halt2_retired", retired, 16'd8);
        step();
        chk("halt2_pc_hold", {10'd0, pc}, 16'd41);
        chk("halt2_flag", {15'd0, flag}, 16'd1);

        // PC wrap 63 -> 0, then reset during WAIT
        rom[0]  = 16'h803F;  // JMP 63
        rom[63] = 16'h107F;  // opcode 2
        start = 1'b1; step(); start = 1'b0;
        chk("start_flag", {15'd0, flag}, 16'd0);
        chk("start_retired", retired, 16'd0);
        chk("start_pc", {10'd0, pc}, 16'd0);
        step(); step();
        chk("pc63", {10'd0, pc}, 16'd63);
        step();
        exp_q.push_back(16'h107F);
        issue_ready = 1'b1; step(); issue_ready = 1'b0;
        done_valid = 1'b1; done_flag = 1'b1; step(); done_valid = 1'b0; done_flag = 1'b0;
        chk("wrap_pc", {10'd0, pc}, 16'd0);
        chk("wrap_retired", retired, 16'd2);
        step(); step(); step();
        exp_q.push_back(16'h107F);
        issue_ready = 1'b1; step(); issue_ready = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst2_pc", {10'd0, pc}, 16'd0);
        chk("rst2_busy", {15'd0, busy}, 16'd0);
        chk("rst2_flag", {15'd0, flag}, 16'd0);
        chk("rst2_issue_op", issue_op, 16'd0);
        done_valid = 1'b1; done_flag = 1'b1; step(); done_valid = 1'b0; done_flag = 1'b0;
        chk("ignored_done_flag", {15'd0, flag}, 16'd0);
        chk("ignored_done_retired", retired, 16'd0);
        chk("ignored_done_busy", {15'd0, busy}, 16'd0);
        chk("scoreboard_empty", exp_q.size(), 16'd0);
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
